huffman_dec: RTL and testbench

HUFFMAN_DEC -- requirements
Module: huffman_dec

---
 rtl/huffman_dec.sv | 114 +++++++++++
 tb/tb_huffman_dec.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/huffman_dec.sv
// Huffman bitstream extractor: packs incoming bytes into a 2*W-bit MSB-aligned
// accumulator and hands out variable-width codes (1..W bits) on request.
// Optional feature: define HUFFMAN_DEC_FLUSH_EN to add a `flush` input that
// drops all buffered bits for byte realignment.
module huffman_dec #(
  parameter int unsigned W = 8,
  parameter int unsigned C = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef HUFFMAN_DEC_FLUSH_EN
  input  logic         flush,
`endif
  input  logic [W-1:0] d_in,
  input  logic         d_valid,
  output logic         d_ready,
  input  logic [C-1:0] w_req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] code_out,
  output logic         out_valid,
  output logic         err
);

  localparam int unsigned AccW = 2 * W;
  localparam int unsigned CntW = $clog2(AccW + 1);

  // Accumulator invariant: bits below the fill level are always zero, so a new
  // byte can simply be OR-ed in at the fill position.
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    code_out_q, code_out_d;
  logic            out_valid_q, out_valid_d;
  logic            err_q, err_d;

  logic            req_legal;
  logic            serve;
  logic            accept;
  logic [CntW-1:0] w_cnt;
  logic [AccW-1:0] acc_c;
  logic [CntW-1:0] cnt_c;
  logic [AccW-1:0] ins;

  // Handshake decode from registered fill count and current request.
  always_comb begin
    req_legal = (w_req != '0) && (32'(w_req) <= W);
    // Only meaningful when req_legal; legal widths always fit the counter.
    w_cnt     = CntW'(w_req);
    d_ready   = (32'(cnt_q) <= W);
    req_ready = req_legal && (cnt_q >= w_cnt);
    serve     = req_valid && req_ready;
    accept    = d_valid && d_ready;
  end

  // Next state: consume the served code first, then append the accepted byte
  // right behind the remaining bits.
  always_comb begin
    acc_c = acc_q;
    cnt_c = cnt_q;
    if (serve) begin
      acc_c = acc_q << w_cnt;
      cnt_c = cnt_q - w_cnt;
    end

    ins   = {d_in, {W{1'b0}}} >> cnt_c;
    acc_d = acc_c;
    cnt_d = cnt_c;
    if (accept) begin
      acc_d = acc_c | ins;
      cnt_d = cnt_c + CntW'(W);
    end

    code_out_d = code_out_q;
    if (serve) begin
      code_out_d = acc_q[AccW-1 -: W] & ~({W{1'b1}} >> w_cnt);
    end
    out_valid_d = serve;
    err_d       = req_valid && !req_legal;

`ifdef HUFFMAN_DEC_FLUSH_EN
    // Flush wins over everything in the same cycle; acc is cleared too so the
    // zero-below-fill invariant holds for the next append.
    if (flush) begin
      acc_d       = '0;
      cnt_d       = '0;
      code_out_d  = code_out_q;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end
`endif
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      code_out_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      code_out_q  <= code_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign code_out  = code_out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_huffman_dec.sv
// Self-checking bench for huffman_dec: directed vector table, a reset-in-stream
// sequence, then randomized traffic against a bit-queue reference model.
module tb_huffman_dec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_in;
  logic       d_valid;
  logic       d_ready;
  logic [3:0] w_req;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] code_out;
  logic       out_valid;
  logic       err;

  always #5 clk = ~clk;

  huffman_dec #(.W(8), .C(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .w_req     (w_req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .code_out  (code_out),
    .out_valid (out_valid),
    .err       (err)
  );

  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic       rv;
    logic [3:0] w;
    logic       e_dr;
    logic       e_rr;
    logic       e_ov;
    logic       e_err;
    logic [7:0] e_code;
  } vec_t;

  int checks = 0;
  int errors = 0;

  vec_t tbl[29];

  // Reference model state: buffered bits in arrival order, last emitted code.
  bit         q[$];
  logic [7:0] m_code;

  function automatic vec_t mk(input logic dv, input logic [7:0] din, input logic rv,
                              input logic [3:0] w, input logic e_dr, input logic e_rr,
                              input logic e_ov, input logic e_err, input logic [7:0] e_code);
    vec_t v;
    v.dv = dv; v.din = din; v.rv = rv; v.w = w;
    v.e_dr = e_dr; v.e_rr = e_rr; v.e_ov = e_ov; v.e_err = e_err; v.e_code = e_code;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive, check ready flags mid-cycle, then
  // check registered outputs just after the next edge.
  task automatic apply(input vec_t v, input string tag);
    d_valid   = v.dv;
    d_in      = v.din;
    req_valid = v.rv;
    w_req     = v.w;
    @(negedge clk);
    chk({tag, " d_ready"}, 32'(d_ready), 32'(v.e_dr));
    chk({tag, " req_ready"}, 32'(req_ready), 32'(v.e_rr));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
    chk({tag, " err"}, 32'(err), 32'(v.e_err));
    chk({tag, " code_out"}, 32'(code_out), 32'(v.e_code));
  endtask

  initial begin
    // Directed vectors from a fresh reset (fill count shown as comments).
    tbl[0]  = mk(1, 8'hB4, 0, 0, 1, 0, 0, 0, 8'h00); // ->8
    tbl[1]  = mk(1, 8'h5A, 0, 0, 1, 0, 0, 0, 8'h00); // ->16
    tbl[2]  = mk(0, 8'h00, 1, 3, 0, 1, 1, 0, 8'hA0); // ->13
    tbl[3]  = mk(0, 8'h00, 1, 5, 0, 1, 1, 0, 8'hA0); // ->8
    tbl[4]  = mk(0, 8'h00, 1, 4, 1, 1, 1, 0, 8'h50); // ->4
    tbl[5]  = mk(0, 8'h00, 0, 5, 1, 0, 0, 0, 8'h50); // cnt<5
    tbl[6]  = mk(0, 8'h00, 0, 4, 1, 1, 0, 0, 8'h50); // cnt>=4
    tbl[7]  = mk(0, 8'h00, 1, 4, 1, 1, 1, 0, 8'hA0); // ->0
    tbl[8]  = mk(0, 8'h00, 1, 4, 1, 0, 0, 0, 8'hA0); // underflow wait
    tbl[9]  = mk(0, 8'h00, 1, 4, 1, 0, 0, 0, 8'hA0);
    tbl[10] = mk(1, 8'hC3, 1, 4, 1, 0, 0, 0, 8'hA0); // byte lands ->8
    tbl[11] = mk(0, 8'h00, 1, 4, 1, 1, 1, 0, 8'hC0); // ->4
    tbl[12] = mk(0, 8'h00, 1, 4, 1, 1, 1, 0, 8'h30); // ->0
    tbl[13] = mk(1, 8'h81, 0, 0, 1, 0, 0, 0, 8'h30); // ->8
    tbl[14] = mk(1, 8'hFF, 0, 0, 1, 0, 0, 0, 8'h30); // ->16
    tbl[15] = mk(1, 8'h11, 0, 0, 0, 0, 0, 0, 8'h30); // full, held off
    tbl[16] = mk(1, 8'h11, 0, 0, 0, 0, 0, 0, 8'h30);
    tbl[17] = mk(1, 8'h11, 1, 8, 0, 1, 1, 0, 8'h81); // ->8
    tbl[18] = mk(1, 8'h22, 0, 0, 1, 0, 0, 0, 8'h81); // accept resumes ->16
    tbl[19] = mk(0, 8'h00, 1, 8, 0, 1, 1, 0, 8'hFF); // ->8
    tbl[20] = mk(0, 8'h00, 1, 8, 1, 1, 1, 0, 8'h22); // ->0
    tbl[21] = mk(1, 8'h81, 0, 0, 1, 0, 0, 0, 8'h22); // ->8
    tbl[22] = mk(1, 8'hFF, 1, 8, 1, 1, 1, 0, 8'h81); // consume+append ->8
    tbl[23] = mk(0, 8'h00, 1, 8, 1, 1, 1, 0, 8'hFF); // ->0
    tbl[24] = mk(1, 8'h5A, 0, 0, 1, 0, 0, 0, 8'hFF); // ->8
    tbl[25] = mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 8'hFF); // illegal w=0
    tbl[26] = mk(0, 8'h00, 1, 9, 1, 0, 0, 1, 8'hFF); // illegal w=9
    tbl[27] = mk(0, 8'h00, 0, 8, 1, 1, 0, 0, 8'hFF); // still 8 bits
    tbl[28] = mk(0, 8'h00, 1, 8, 1, 1, 1, 0, 8'h5A); // ->0

    rst_n     = 1'b0;
    d_in      = '0;
    d_valid   = 1'b0;
    req_valid = 1'b0;
    w_req     = 4'd1;
    #12;
    chk("reset code_out", 32'(code_out), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset d_ready", 32'(d_ready), 32'h1);
    chk("reset req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a stream at fill 11.
    apply(mk(1, 8'hAB, 0, 0, 1, 0, 0, 0, 8'h5A), "mid_a");
    apply(mk(1, 8'hCD, 0, 0, 1, 0, 0, 0, 8'h5A), "mid_b");
    apply(mk(0, 8'h00, 1, 5, 0, 1, 1, 0, 8'hA8), "mid_c");
    rst_n     = 1'b0;
    req_valid = 1'b0;
    w_req     = 4'd1;
    d_valid   = 1'b1;
    d_in      = 8'h80;
    #1;
    chk("midrst code_out", 32'(code_out), 32'h0);
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst err", 32'(err), 32'h0);
    chk("midrst d_ready", 32'(d_ready), 32'h1);
    chk("midrst req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Byte must have landed on the first edge after release.
    apply(mk(0, 8'h00, 1, 1, 1, 1, 1, 0, 8'h80), "post_rst");

    // Fresh start for randomized traffic.
    rst_n = 1'b0;
    d_valid = 1'b0;
    req_valid = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    m_code = 8'h00;

    for (int n = 0; n < 600; n++) begin
      vec_t v;
      bit   legal;
      bit   serve;
      bit   acc;
      v.dv  = ($urandom_range(0, 2) != 0);
      v.din = 8'($urandom);
      v.rv  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) != 0) v.w = 4'($urandom_range(1, 8));
      else v.w = 4'($urandom_range(0, 15));

      legal   = (v.w >= 1) && (v.w <= 8);
      v.e_dr  = (q.size() <= 8);
      v.e_rr  = legal && (q.size() >= int'(v.w));
      serve   = v.rv && v.e_rr;
      acc     = v.dv && v.e_dr;
      v.e_err = v.rv && !legal;
      v.e_ov  = serve;
      if (serve) begin
        m_code = 8'h00;
        for (int j = 0; j < int'(v.w); j++) m_code[7-j] = q.pop_front();
      end
      if (acc) begin
        for (int j = 7; j >= 0; j--) q.push_back(v.din[j]);
      end
      v.e_code = m_code;
      apply(v, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
